// File: rtl/nexus_dmem_pkg.sv
// -----------------------------------------------------------------------------
// nexus_dmem_pkg
// Shared definitions for the data-memory arbiter and its neighbours:
//   - RISC-V load/store funct3 encodings (LB..LHU, SB..SW)
//   - arbiter state encoding (ARB, APB_RESP)
//   - DMEM_BYTES: size of the data memory in bytes
// -----------------------------------------------------------------------------
package nexus_dmem_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Data memory size (4 KiB)
  localparam int unsigned DMEM_BYTES = 4096;

  // Arbiter state: ARB = memory free, APB_RESP = APB access issued last cycle
  typedef enum logic {
    ST_ARB      = 1'b0,
    ST_APB_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the core load/store unit and an
// APB slave port (debug/DMA). The core has fixed priority; an APB ACCESS phase
// denied for STARVE_MAX consecutive cycles wins the next arbitration.
// The memory read is 1-cycle synchronous, so completions are reported one cycle
// after the grant: core_done for the core, pready (APB_RESP state) for APB.
//
// Handshakes:
//   core side : core_req is held until core_gnt (combinational). Exactly one
//               cycle after every grant core_done pulses with core_rdata/core_err.
//   APB side  : standard APB; SETUP phase (psel & !penable) is never granted.
//               In ACCESS (psel & penable) pready stays 0 until the cycle after
//               the grant, when pready/prdata/pslverr are presented for one cycle.
//
// Parameters:
//   STARVE_MAX : max consecutive denied APB ACCESS cycles (1..15)
//   MEM_AW     : byte-address width of the memory; paddr >= 2**MEM_AW errors
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   core_req/we/addr/wdata/funct3       core request
//   core_gnt/done/rdata/err             core grant and completion
//   psel/penable/pwrite/paddr/pwdata    APB request
//   pready/prdata/pslverr               APB response
//   mem_read_en/write_en/address/
//   mem_write_data/funct3               memory request
//   mem_read_data, mem_misaligned       memory response / misalign flag
//   dbg_state                           current arbiter state
//
// Configuration macro:
//   DMEM_ARB_APB_WRITE_EN : when defined APB writes reach the memory; when
//                           undefined they are granted but suppressed and
//                           answered with pslverr = 1.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import nexus_dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MEM_AW     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  // core LSU
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic        core_gnt,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic        core_err,
  // APB slave
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  // data memory
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  input  logic        mem_misaligned,
  // debug
  output arb_state_e  dbg_state
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] APB_LIMIT  = 32'(64'd1 << MEM_AW);

`ifdef DMEM_ARB_APB_WRITE_EN
  localparam logic APB_WR_OK = 1'b1;
`else
  localparam logic APB_WR_OK = 1'b0;
`endif

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;

  logic        r_core_done;
  logic        r_core_load;
  logic        r_core_err;
  logic        r_apb_read;
  logic        r_apb_err;

  logic        w_apb_access;
  logic        w_apb_gnt;
  logic        w_core_gnt;
  logic        w_range_err;
  logic        w_apb_err;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    w_apb_access = psel & penable;
    w_range_err  = (paddr >= APB_LIMIT);
    // APB only wins from ARB; in APB_RESP the memory is free again but the
    // APB port is still completing, so only the core can use it.
    w_apb_gnt    = (r_state == ST_ARB) && w_apb_access &&
                   (!core_req || (r_starve_cnt == STARVE_LIM));
    w_core_gnt   = core_req && !w_apb_gnt;
  end

  // Error captured at APB grant: misaligned word, out of range, or a write
  // while APB writes are disabled. mem_misaligned is valid here because the
  // memory sees paddr/LW in the APB grant cycle.
  assign w_apb_err = mem_misaligned | w_range_err | (pwrite & ~APB_WR_OK);

  // ---------------------------------------------------------------------------
  // Memory request mux. When idle the core fields pass through (don't-care).
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = core_addr;
    mem_write_data = core_wdata;
    mem_funct3     = core_funct3;
    if (w_apb_gnt) begin
      mem_address    = paddr;
      mem_write_data = pwdata;
      mem_funct3     = F3_LW;
      mem_read_en    = !pwrite && !w_range_err;
      mem_write_en   = pwrite && !w_range_err && APB_WR_OK;
    end else if (w_core_gnt) begin
      mem_read_en    = !core_we;
      mem_write_en   = core_we;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and starvation counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = ST_ARB;
    w_starve_nxt = r_starve_cnt;
    if (w_apb_gnt) begin
      w_state_nxt = ST_APB_RESP;
    end
    if (!psel || w_apb_gnt) begin
      w_starve_nxt = 4'd0;
    end else if ((r_state == ST_ARB) && w_apb_access && w_core_gnt &&
                 (r_starve_cnt != STARVE_LIM)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ARB;
      r_starve_cnt <= 4'd0;
      r_core_done  <= 1'b0;
      r_core_load  <= 1'b0;
      r_core_err   <= 1'b0;
      r_apb_read   <= 1'b0;
      r_apb_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_core_done  <= w_core_gnt;
      r_core_load  <= w_core_gnt & ~core_we;
      r_core_err   <= w_core_gnt & mem_misaligned;
      if (w_apb_gnt) begin
        r_apb_read <= ~pwrite;
        r_apb_err  <= w_apb_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    core_gnt   = w_core_gnt;
    core_done  = r_core_done;
    core_err   = r_core_err;
    core_rdata = r_core_load ? mem_read_data : 32'h0;
    pready     = (r_state == ST_APB_RESP);
    pslverr    = pready & r_apb_err;
    prdata     = (pready && r_apb_read && !r_apb_err) ? mem_read_data : 32'h0;
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives dmem_arbiter with directed and randomized core/APB traffic. A small
// byte-array data memory sits behind the arbiter; a separate reference byte
// array tracks what memory should contain according to RISC-V load/store
// semantics and the arbitration rules. Honors DMEM_ARB_APB_WRITE_EN.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import nexus_dmem_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int MEM_AW     = 12;
`ifdef DMEM_ARB_APB_WRITE_EN
  localparam bit APB_WR_EN = 1'b1;
`else
  localparam bit APB_WR_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst_n;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic        core_gnt, core_done, core_err;
  logic [31:0] core_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_address, mem_write_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;
  logic        mem_misaligned;
  arb_state_e  dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
    .core_err(core_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_funct3(mem_funct3), .mem_read_data(mem_read_data),
    .mem_misaligned(mem_misaligned), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Load/store helpers (RISC-V semantics, little-endian)
  // ---------------------------------------------------------------------------
  function automatic logic f_mis(input logic [31:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a[1:0] != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_fmt(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3,
                                        input logic [2:0] f3);
    case (f3)
      F3_LB:   return {{24{b0[7]}}, b0};
      F3_LH:   return {{16{b1[7]}}, b1, b0};
      F3_LW:   return {b3, b2, b1, b0};
      F3_LBU:  return {24'h0, b0};
      F3_LHU:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Data memory behind the arbiter: 1-cycle synchronous read, misaligned
  // stores are dropped, misalign flag is combinational.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_arr [0:DMEM_BYTES-1];
  logic [7:0]  ref_mem [0:DMEM_BYTES-1];
  logic [31:0] mem_rd_q;
  logic [11:0] ma0;

  assign ma0            = mem_address[11:0];
  assign mem_read_data  = mem_rd_q;
  assign mem_misaligned = f_mis(mem_address, mem_funct3);

  initial begin
    for (int i = 0; i < DMEM_BYTES; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_rd_q = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_read_en)
        mem_rd_q = f_fmt(mem_arr[ma0], mem_arr[ma0 + 12'd1], mem_arr[ma0 + 12'd2],
                         mem_arr[ma0 + 12'd3], mem_funct3);
      if (mem_write_en && !mem_misaligned)
        for (int k = 0; k < (1 << mem_funct3[1:0]); k++)
          mem_arr[ma0 + 12'(k)] = mem_write_data[8*k +: 8];
    end
  end

  // Reference memory model
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [11:0] i;
    i = a[11:0];
    return f_fmt(ref_mem[i], ref_mem[i + 12'd1], ref_mem[i + 12'd2], ref_mem[i + 12'd3], f3);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int k = 0; k < (1 << f3[1:0]); k++)
      ref_mem[a[11:0] + 12'(k)] = wd[8*k +: 8];
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Core scoreboard: each grant pushes {err, rdata}; each done pops it.
  logic [32:0] exp_q[$];

  initial begin
    bit          prev_gnt;
    logic [32:0] e;
    logic        er;
    prev_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_gnt = 1'b0;
      end else begin
        if (prev_gnt || core_done) chk("core_done_pulse", 32'(core_done), 32'(prev_gnt));
        if (core_done && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_core_err", 32'(core_err), 32'(e[32]));
          if (!e[32]) chk("sb_core_rdata", core_rdata, e[31:0]);
        end
        prev_gnt = core_gnt;
        if (core_gnt) begin
          chk("core_gnt_has_req", 32'(core_req), 32'd1);
          er = f_mis(core_addr, core_funct3);
          if (core_we) begin
            if (!er) ref_store(core_addr, core_funct3, core_wdata);
            e = {er, 32'h0};
          end else begin
            e = {er, ref_load(core_addr, core_funct3)};
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  bit hammer_stop = 1'b0;

  // Single core access with APB idle: grant expected immediately.
  task automatic core_single(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = wd; core_funct3 = f3;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (core_gnt) got = 1'b1;
    end
    chk("core_gnt_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    core_req = 1'b0;
    @(negedge clk);
    chk("core_done_after_gnt", 32'(core_done), 32'd1);
    rd = core_rdata;
    er = core_err;
  endtask

  task automatic drive_rand_core();
    int k;
    core_we = 1'($urandom_range(0, 1));
    if (core_we) begin
      core_funct3 = 3'($urandom_range(0, 2));
    end else begin
      k = $urandom_range(0, 4);
      core_funct3 = (k < 3) ? 3'(k) : 3'(k + 1);
    end
    core_addr  = 32'($urandom_range(0, 1023));
    core_wdata = $urandom;
    core_req   = 1'b1;
  endtask

  // Random core traffic until hammer_stop; always_req keeps core_req high.
  task automatic core_hammer(input bit always_req);
    int cyc;
    bit granted;
    cyc = 0;
    @(posedge clk); #1;
    drive_rand_core();
    while (cyc < 300) begin
      @(negedge clk);
      granted = core_req && core_gnt;
      @(posedge clk); #1;
      cyc++;
      if (!core_req || granted) begin
        if (hammer_stop) break;
        if (always_req || $urandom_range(0, 2) != 0) drive_rand_core();
        else core_req = 1'b0;
      end
    end
    core_req = 1'b0;
  endtask

  // One APB transfer. The reference decides, per ACCESS cycle, whether APB is
  // granted (core idle, or STARVE_MAX denials already suffered) and checks
  // pready is low until the cycle after that grant.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          output int ready_cyc, output logic [31:0] rd_o, output logic err_o);
    int          n, denies;
    bit          granted, done;
    logic        e_err;
    logic [31:0] e_rd;
    n = 0; denies = 0; granted = 1'b0; done = 1'b0;
    ready_cyc = 0; rd_o = 32'h0; err_o = 1'b0; e_err = 1'b0; e_rd = 32'h0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    chk("apb_setup_pready", 32'(pready), 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      if (pready && ready_cyc == 0) ready_cyc = n;
      if (granted) begin
        chk("apb_pready", 32'(pready), 32'd1);
        chk("apb_pslverr", 32'(pslverr), 32'(e_err));
        chk("apb_prdata", prdata, e_rd);
        rd_o = prdata;
        err_o = pslverr;
        done = 1'b1;
      end else begin
        chk("apb_wait_pready", 32'(pready), 32'd0);
        if (!core_req || denies == STARVE_MAX) begin
          granted = 1'b1;
          if (core_req) chk("apb_gnt_blocks_core", 32'(core_gnt), 32'd0);
          e_err = (a >= (32'h1 << MEM_AW)) || (a[1:0] != 2'b00) || (wr && !APB_WR_EN);
          if (wr && !e_err) ref_store(a, F3_SW, wd);
          e_rd = (!wr && !e_err) ? ref_load(a, F3_LW) : 32'h0;
        end else begin
          denies++;
        end
      end
    end
    if (!done) chk("apb_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          rc;
    logic        wr;
    logic [31:0] a;
    int          sel;

    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_funct3 = 3'h0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_done", 32'(core_done), 32'd0);
    chk("rst_ctrl_bits", 32'({core_gnt, core_err, pready, pslverr, mem_read_en, mem_write_en}), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_ARB));
    #3 rst_n = 1'b1;

    // Core SW then LW back to back
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'hDEADBEEF; core_funct3 = F3_SW;
    @(negedge clk);
    chk("b2b_sw_gnt", 32'(core_gnt), 32'd1);
    @(posedge clk); #1;
    core_we = 1'b0; core_wdata = 32'h0; core_funct3 = F3_LW;
    @(negedge clk);
    chk("b2b_lw_gnt", 32'(core_gnt), 32'd1);
    chk("b2b_sw_done", 32'(core_done), 32'd1);
    chk("b2b_sw_rdata", core_rdata, 32'h0);
    @(posedge clk); #1;
    core_req = 1'b0;
    @(negedge clk);
    chk("b2b_lw_done", 32'(core_done), 32'd1);
    chk("b2b_lw_rdata", core_rdata, 32'hDEADBEEF);
    chk("b2b_lw_err", 32'(core_err), 32'd0);

    // Sign-extended halfword and misaligned word
    core_single(1'b0, 32'h102, 32'h0, F3_LH, rd, er);
    chk("lh_102_rdata", rd, 32'hFFFFDEAD);
    chk("lh_102_err", 32'(er), 32'd0);
    core_single(1'b0, 32'h101, 32'h0, F3_LW, rd, er);
    chk("lw_101_err", 32'(er), 32'd1);

    // APB read with core idle
    apb_xfer(1'b0, 32'h100, 32'h0, rc, rd, er);
    chk("apb_rd_ready_cycle", 32'(rc), 32'd2);
    chk("apb_rd_data", rd, 32'hDEADBEEF);
    chk("apb_rd_err", 32'(er), 32'd0);

    // APB misaligned read
    apb_xfer(1'b0, 32'h102, 32'h0, rc, rd, er);
    chk("apb_mis_err", 32'(er), 32'd1);
    chk("apb_mis_data", rd, 32'h0);

    // Starvation bound, twice (counter must restart from 0)
    for (int t = 0; t < 2; t++) begin
      hammer_stop = 1'b0;
      fork
        core_hammer(1'b1);
        begin
          apb_xfer(1'b0, 32'h100, 32'h0, rc, rd, er);
          hammer_stop = 1'b1;
        end
      join
      chk("starve_ready_cycle", 32'(rc), 32'(STARVE_MAX + 2));
    end
    hammer_stop = 1'b0;

    // Out-of-range APB write must not alias onto address 0
    core_single(1'b1, 32'h000, 32'h12345678, F3_SW, rd, er);
    apb_xfer(1'b1, 32'h0000_1000, 32'hCAFEF00D, rc, rd, er);
    chk("apb_range_err", 32'(er), 32'd1);
    core_single(1'b0, 32'h000, 32'h0, F3_LW, rd, er);
    chk("range_readback", rd, 32'h12345678);

    // In-range APB write: depends on DMEM_ARB_APB_WRITE_EN
    core_single(1'b1, 32'h004, 32'h11111111, F3_SW, rd, er);
    apb_xfer(1'b1, 32'h004, 32'hA5A5A5A5, rc, rd, er);
    chk("apb_wr_err", 32'(er), APB_WR_EN ? 32'd0 : 32'd1);
    core_single(1'b0, 32'h004, 32'h0, F3_LW, rd, er);
    chk("apb_wr_readback", rd, APB_WR_EN ? 32'hA5A5A5A5 : 32'h11111111);

    // Randomized mixed traffic
    for (int it = 0; it < 30; it++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h1000 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (sel == 1) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else               a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      hammer_stop = 1'b0;
      fork
        core_hammer(1'($urandom_range(0, 1)));
        begin
          apb_xfer(wr, a, $urandom, rc, rd, er);
          hammer_stop = 1'b1;
        end
      join
    end
    hammer_stop = 1'b0;

    // Reset the cycle after a core load grant
    core_single(1'b1, 32'h3F0, 32'h0BADF00D, F3_SW, rd, er);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h3F0; core_funct3 = F3_LW;
    @(negedge clk);
    chk("rst_mid_gnt", 32'(core_gnt), 32'd1);
    @(posedge clk); #1;
    core_req = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_funct3 = 3'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_done", 32'(core_done), 32'd0);
    chk("rst_mid_ctrl", 32'({core_gnt, core_err, pready, pslverr, mem_read_en, mem_write_en}), 32'd0);
    chk("rst_mid_rdata", core_rdata, 32'h0);
    chk("rst_mid_addr", mem_address, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    core_single(1'b0, 32'h3F0, 32'h0, F3_LW, rd, er);
    chk("post_rst_rdata", rd, 32'h0BADF00D);
    chk("post_rst_err", 32'(er), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core load/store unit and an APB slave port used for debug/DMA.
- Sequences the memory's 1-cycle synchronous read and generates completion pulses on both sides.
- Core has fixed priority, with a bounded-starvation guarantee for APB.
- Sits between the core LSU/APB interconnect and the data memory in the core_apb subsystem.

Parameters:
- STARVE_MAX, 4, max consecutive cycles an APB ACCESS phase may be denied while core_req is high; range 1..15.
- MEM_AW, 12, byte-address width of the data memory (4 KiB); APB addresses at or above 2**MEM_AW are errors.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core access request, held until core_gnt
- core_we  in  1  1 = store, 0 = load
- core_addr  in  32  byte address
- core_wdata  in  32  store data (unaligned; memory replicates)
- core_funct3  in  3  RISC-V load/store funct3
- core_gnt  out  1  combinational; request accepted this cycle
- core_done  out  1  pulses the cycle after every grant
- core_rdata  out  32  load data, valid when core_done and the op was a load
- core_err  out  1  valid with core_done; access was misaligned
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  32  APB byte address (word accesses only)
- pwdata  in  32  APB write data
- pready  out  1  APB ready
- prdata  out  32  APB read data
- pslverr  out  1  APB error
- mem_read_en, mem_write_en  out  1 each  to memory
- mem_address, mem_write_data  out  32 each  to memory
- mem_funct3  out  3  to memory
- mem_read_data  in  32  memory formatted read data (1 cycle after read_en)
- mem_misaligned  in  1  memory combinational misalign flag

Behaviour:
- Reset: all outputs 0, state ARB, starve counter 0, all registered flags 0. Mid-transaction reset drops any pending done/pready without reissue.
- States:
  - ARB: memory free.
  - APB_RESP: APB access issued last cycle; pready = 1 this cycle.
- Grant rule (in both states):
  - APB wins if the state is ARB, psel&penable is high, and (core_req == 0 or starve_cnt == STARVE_MAX). Otherwise core_req wins.
  - No APB grant in APB_RESP.
- Core grant:
  - core_gnt = 1; mem_* driven from core_* with read_en = !core_we and write_en = core_we.
  - Next cycle: core_done = 1, core_err = registered mem_misaligned, core_rdata = mem_read_data (0 if store).
  - Back-to-back grants are allowed: one access per cycle, full throughput.
- APB grant:
  - mem_funct3 = 3'b010 (LW/SW); mem_address = paddr; read_en = !pwrite, write_en = pwrite.
  - Go to APB_RESP.
  - If paddr >= 2**MEM_AW: both enables 0, and the error flag is set.
- APB_RESP:
  - pready = 1; prdata = mem_read_data for a read, else 0.
  - pslverr = registered (mem_misaligned | range error). On error, prdata = 0.
  - Return to ARB. The core may be granted in this cycle.
- pready is 0 in every other cycle, including the SETUP phase. Wait states are inserted while denied.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each ARB cycle in which APB ACCESS is pending and the core wins.
  - Clears on APB grant and whenever psel is 0.
- Simultaneous request when starve_cnt == STARVE_MAX: APB wins; core_gnt = 0 and the core holds its request.
- Idle: mem enables 0; address, wdata and funct3 hold the core values (don't-care).

Optional Feature:
- DMEM_ARB_APB_WRITE_EN
- Defined: APB writes are performed as above.
- Undefined: APB writes are granted, but mem_write_en stays 0 and pslverr = 1 in APB_RESP; APB reads are unaffected.

Decomposition:
- Shared package nexus_dmem_pkg:
  - funct3 load/store localparams (LB..LHU, SB..SW)
  - state encoding (ARB, APB_RESP)
  - DMEM_BYTES constant
- No sub-module; the starve counter and FSM are inline. The testbench instantiates data_mem behind the arbiter.

Test Plan:
- Core SW 0x100 ← 0xDEADBEEF, then LW 0x100 on the next cycle -> gnt both cycles; done pulses; rdata = 0xDEADBEEF, err = 0.
- Core LH 0x102 after the previous write -> core_rdata = 0xFFFFDEAD. Core LW 0x101 -> core_err = 1 with core_done.
- APB read of 0x100 with core idle -> pready on the 2nd ACCESS cycle; prdata = 0xDEADBEEF; pslverr = 0.
- core_req held high continuously with APB ACCESS pending, STARVE_MAX = 4 -> exactly 4 wait cycles, then APB granted (core_gnt = 0 that cycle); counter returns to 0.
- APB write paddr = 0x0000_1000 -> pslverr = 1, no memory change (a core readback of 0x000 is unchanged). Without DMEM_ARB_APB_WRITE_EN, an APB write to 0x004 -> pslverr = 1 and memory unchanged.
- Assert rst_n low the cycle after a core load grant -> core_done stays 0 and all outputs are 0. After release, the first grant works normally.
